// File: rtl/cache_mem_responder.sv
// Fixed-latency word RAM serving a dcache (read/write) port and an icache (read-only) port.
// Optional CACHE_MEM_STATS_EN adds per-port completed-transaction counters.
module cache_mem_responder #(
  parameter int unsigned LAT       = 2,
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload
`ifdef CACHE_MEM_STATS_EN
  ,
  output logic [31:0] dstat_reads,
  output logic [31:0] dstat_writes,
  output logic [31:0] istat_reads
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   owner_d_q, owner_d_d;
  logic                   wr_q, wr_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dwait_q, dwait_d;
  logic                   iwait_q, iwait_d;
  logic [31:0]            dload_q, dload_d;
  logic [31:0]            iload_q, iload_d;
  logic [31:0]            rd_data_c;
  logic                   go_c;
  logic [31:0]            mem_q [DEPTH];

  // Byte offset and high address bits alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{daddr[31:ADDR_BITS+2], daddr[1:0],
                              iaddr[31:ADDR_BITS+2], iaddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      dwait_q   <= 1'b1;
      iwait_q   <= 1'b1;
      dload_q   <= '0;
      iload_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      dwait_q   <= dwait_d;
      iwait_q   <= iwait_d;
      dload_q   <= dload_d;
      iload_q   <= iload_d;
    end
  end

  // Write commits on the edge that ends RESP; a reset in that cycle discards it.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == RESP && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    go_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          go_c      = 1'b1;
          owner_d_d = 1'b1;
          wr_d      = dWEN;
          idx_d     = daddr[ADDR_BITS+1:2];
          wdata_d   = dstore;
        end else if (iREN) begin
          go_c      = 1'b1;
          owner_d_d = 1'b0;
          wr_d      = 1'b0;
          idx_d     = iaddr[ADDR_BITS+1:2];
        end
        if (go_c) begin
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(LAT - 2);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they line up with RESP.
    rd_data_c = mem_q[idx_d];
    dwait_d   = ~(state_d == RESP && owner_d_d);
    iwait_d   = ~(state_d == RESP && !owner_d_d);
    dload_d   = dload_q;
    iload_d   = iload_q;
    if (state_d == RESP && state_q != RESP && !wr_d) begin
      if (owner_d_d) dload_d = rd_data_c;
      else           iload_d = rd_data_c;
    end
  end

  assign dwait = dwait_q;
  assign iwait = iwait_q;
  assign dload = dload_q;
  assign iload = iload_q;

`ifdef CACHE_MEM_STATS_EN
  logic [31:0] dstat_reads_q, dstat_writes_q, istat_reads_q;

  // Saturating counters bump once in each completed RESP cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dstat_reads_q  <= '0;
      dstat_writes_q <= '0;
      istat_reads_q  <= '0;
    end else if (state_q == RESP) begin
      if (owner_d_q && wr_q && dstat_writes_q != 32'hFFFF_FFFF)
        dstat_writes_q <= dstat_writes_q + 32'd1;
      if (owner_d_q && !wr_q && dstat_reads_q != 32'hFFFF_FFFF)
        dstat_reads_q <= dstat_reads_q + 32'd1;
      if (!owner_d_q && istat_reads_q != 32'hFFFF_FFFF)
        istat_reads_q <= istat_reads_q + 32'd1;
    end
  end

  assign dstat_reads  = dstat_reads_q;
  assign dstat_writes = dstat_writes_q;
  assign istat_reads  = istat_reads_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder (LAT=2, ADDR_BITS=14); stats checks under CACHE_MEM_STATS_EN.
module tb_cache_mem_responder;

  localparam int LAT = 2;

  logic        CLK, RST;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr;
  logic        dwait, iwait;
  logic [31:0] dload, iload;
`ifdef CACHE_MEM_STATS_EN
  logic [31:0] dstat_reads, dstat_writes, istat_reads;
`endif

  cache_mem_responder #(.LAT(LAT), .ADDR_BITS(14)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef CACHE_MEM_STATS_EN
    , .dstat_reads(dstat_reads), .dstat_writes(dstat_writes), .istat_reads(istat_reads)
`endif
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        dq[$];
  exp_t        iq[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [31:0] last_d = 32'h0;
  logic [31:0] last_i = 32'h0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a wait line drops.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      last_d = 32'h0;
      last_i = 32'h0;
    end
    if (!dwait && !iwait) begin
      checks++; fails++;
      $display("FAIL both_waits_low at cycle %0d", cyc);
    end
    if (!dwait) begin
      if (dq.size() == 0) begin
        checks++; fails++;
        $display("FAIL d_unexpected_resp at cycle %0d", cyc);
      end else begin
        e = dq.pop_front();
        chk("d_resp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) begin
          chk("d_read_data", dload, e.data);
          last_d = e.data;
        end else begin
          chk("d_load_held_on_write", dload, last_d);
        end
      end
    end
    if (!iwait) begin
      if (iq.size() == 0) begin
        checks++; fails++;
        $display("FAIL i_unexpected_resp at cycle %0d", cyc);
      end else begin
        e = iq.pop_front();
        chk("i_resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("i_read_data", iload, e.data);
        last_i = e.data;
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while ((dq.size() != 0 || iq.size() != 0) && t < 20) begin
      @(negedge CLK); #1;
      t++;
    end
    if (dq.size() != 0 || iq.size() != 0) begin
      checks++; fails++;
      $display("FAIL resp_timeout: %0d d and %0d i responses outstanding", dq.size(), iq.size());
      dq.delete();
      iq.delete();
    end
  endtask

  task automatic do_d(input logic ren, input logic wen, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    @(negedge CLK);
    dREN = ren; dWEN = wen; daddr = a; dstore = wd;
    e.rd = ~wen; e.data = exp_rd; e.cyc = cyc + LAT;
    dq.push_back(e);
    @(negedge CLK);
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'hFFFF_FFFF; dstore = 32'h0;
    wait_done();
  endtask

  task automatic do_i(input logic [31:0] a, input logic [31:0] exp_rd);
    exp_t e;
    @(negedge CLK);
    iREN = 1'b1; iaddr = a;
    e.rd = 1'b1; e.data = exp_rd; e.cyc = cyc + LAT;
    iq.push_back(e);
    @(negedge CLK);
    iREN = 1'b0; iaddr = 32'hFFFF_FFFF;
    wait_done();
  endtask

  initial begin
    exp_t e;
    RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; iaddr = 32'h0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_dwait", 32'(dwait), 32'd1);
    chk("reset_iwait", 32'(iwait), 32'd1);
    chk("reset_dload", dload, 32'h0);
    chk("reset_iload", iload, 32'h0);
    RST = 1'b0;

    // Write then read 0x40; icache sees the same word.
    do_d(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0);
    do_d(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    do_i(32'h40, 32'hDEAD_BEEF);

    do_d(1'b0, 1'b1, 32'h80, 32'h55AA_55AA, 32'h0);
    do_d(1'b0, 1'b1, 32'h00, 32'h0BAD_F00D, 32'h0);

    // Simultaneous d and i requests: d first, i LAT+1 later.
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h80; iREN = 1'b1; iaddr = 32'h0;
    e.rd = 1'b1; e.data = 32'h55AA_55AA; e.cyc = cyc + 2; dq.push_back(e);
    e.rd = 1'b1; e.data = 32'h0BAD_F00D; e.cyc = cyc + 5; iq.push_back(e);
    @(negedge CLK);
    dREN = 1'b0;
    repeat (3) @(negedge CLK);
    iREN = 1'b0;
    wait_done();

    // REN and WEN together behave as a write.
    do_d(1'b1, 1'b1, 32'h80, 32'h1234_5678, 32'h0);
    do_d(1'b1, 1'b0, 32'h80, 32'h0, 32'h1234_5678);

    // High and byte-offset address bits alias.
    do_d(1'b0, 1'b1, 32'h0001_0004, 32'hCAFE_F00D, 32'h0);
    do_d(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D);
    do_d(1'b1, 1'b0, 32'h0000_0007, 32'h0, 32'hCAFE_F00D);
    do_i(32'h0000_0005, 32'hCAFE_F00D);

    // Reset during ACCESS drops the pending write.
    do_d(1'b0, 1'b1, 32'h100, 32'h1111_1111, 32'h0);
    @(negedge CLK);
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hAAAA_5555;
    @(negedge CLK);
    dWEN = 1'b0; daddr = 32'hFFFF_FFFF; dstore = 32'h0;
    RST = 1'b1;
    @(negedge CLK); #1;
    chk("rst_mid_dwait", 32'(dwait), 32'd1);
    chk("rst_mid_iwait", 32'(iwait), 32'd1);
    chk("rst_mid_dload", dload, 32'h0);
    chk("rst_mid_iload", iload, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    do_d(1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_1111);

`ifdef CACHE_MEM_STATS_EN
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    do_d(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    do_d(1'b0, 1'b1, 32'h200, 32'h0000_0001, 32'h0);
    do_d(1'b1, 1'b0, 32'h200, 32'h0, 32'h0000_0001);
    do_d(1'b1, 1'b1, 32'h204, 32'h0000_0002, 32'h0);
    do_d(1'b1, 1'b0, 32'h204, 32'h0, 32'h0000_0002);
    do_i(32'h200, 32'h0000_0001);
    @(negedge CLK); #1;
    chk("stat_d_reads", dstat_reads, 32'd3);
    chk("stat_d_writes", dstat_writes, 32'd2);
    chk("stat_i_reads", istat_reads, 32'd1);
    RST = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0;
    chk("stat_rst_d_reads", dstat_reads, 32'd0);
    chk("stat_rst_d_writes", dstat_writes, 32'd0);
    chk("stat_rst_i_reads", istat_reads, 32'd0);
`endif

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
